// File: rtl/core_run_controller_if.sv
// Program-load stream and BRAM write port between the host/loader, the run controller
// and the core memory.
interface core_run_controller_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_ADDRESS_BITS = 14
);
  logic                        load_valid;
  logic [DATA_WIDTH-1:0]       load_data;
  logic                        load_ready;
  logic                        mem_we;
  logic [MEM_ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]       mem_wdata;
  logic [DATA_WIDTH/8-1:0]     mem_byte_en;

  // controller side
  modport master (
    input  load_valid, load_data,
    output load_ready, mem_we, mem_addr, mem_wdata, mem_byte_en
  );

  // host / memory side
  modport slave (
    output load_valid, load_data,
    input  load_ready, mem_we, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/core_run_controller.sv
// Run sequencer for a single-cycle BRAM core: load program image, hold reset, pulse
// start, watch for halt PCs, drain, then report done / cycle count / timeout.
module core_run_controller #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14,
  parameter int RESET_CYCLES     = 4,
  parameter int DRAIN_CYCLES     = 50,
  parameter int MAX_CYCLES       = 1000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_start,
  input  logic                        cmd_abort,
  input  logic [MEM_ADDRESS_BITS:0]   load_words,
  core_run_controller_if.master       bus,
  input  logic [ADDRESS_BITS-1:0]     cfg_program_address,
  input  logic [ADDRESS_BITS-1:0]     cfg_halt_pc0,
  input  logic [ADDRESS_BITS-1:0]     cfg_halt_pc1,
  output logic                        core_reset,
  output logic                        core_start,
  output logic [ADDRESS_BITS-1:0]     core_program_address,
  input  logic [ADDRESS_BITS-1:0]     pc,
  output logic                        busy,
  output logic                        done,
  output logic                        timed_out,
  output logic [31:0]                 cycle_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RESET_HOLD, START, RUN, DRAIN, DONE
  } state_t;

  localparam logic [MEM_ADDRESS_BITS:0] WORDS_ONE = 1;
  localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] COUNT_LAST = 32'(MAX_CYCLES - 1);

  state_t state, state_next;

  logic [MEM_ADDRESS_BITS:0] word_cnt;
  logic [MEM_ADDRESS_BITS:0] load_words_q;
  logic [31:0]               step_cnt;
  logic [ADDRESS_BITS-1:0]   boot_q, halt0_q, halt1_q;
  logic                      timed_out_q;

  logic abort, start_ok, halt_hit, accept;

  always_comb begin
    state_next      = state;
    abort           = cmd_abort && (state != IDLE);
    start_ok        = cmd_start && (state == IDLE || state == DONE);
    halt_hit        = (pc == halt0_q) || (pc == halt1_q);
    accept          = 1'b0;
    bus.load_ready  = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = word_cnt[MEM_ADDRESS_BITS-1:0];
    bus.mem_wdata   = '0;
    bus.mem_byte_en = '0;

    unique case (state)
      IDLE, DONE: begin
        if (start_ok)
          state_next = (load_words != '0) ? LOAD : RESET_HOLD;
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          accept = 1'b1;
          if (word_cnt == load_words_q - WORDS_ONE)
            state_next = RESET_HOLD;
        end
      end
      RESET_HOLD: begin
        if (step_cnt == HOLD_LAST)
          state_next = START;
      end
      START: state_next = RUN;
      RUN: begin
        if (halt_hit)
          state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        else if (cycle_count == COUNT_LAST)
          state_next = DONE;
      end
      DRAIN: begin
        if (step_cnt == DRAIN_LAST)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase

    // abort overrides everything, including a write handshake in the same cycle
    if (abort) begin
      state_next     = IDLE;
      accept         = 1'b0;
      bus.load_ready = 1'b0;
    end

    if (accept) begin
      bus.mem_we      = 1'b1;
      bus.mem_wdata   = bus.load_data;
      bus.mem_byte_en = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      word_cnt             <= '0;
      load_words_q         <= '0;
      step_cnt             <= '0;
      boot_q               <= '0;
      halt0_q              <= '0;
      halt1_q              <= '0;
      timed_out_q          <= 1'b0;
      cycle_count          <= '0;
      core_program_address <= '0;
    end else begin
      state    <= state_next;
      step_cnt <= (state_next != state) ? '0 : step_cnt + 32'd1;

      if (start_ok && !abort) begin
        boot_q       <= cfg_program_address;
        halt0_q      <= cfg_halt_pc0;
        halt1_q      <= cfg_halt_pc1;
        load_words_q <= load_words;
        word_cnt     <= '0;
        cycle_count  <= '0;
        timed_out_q  <= 1'b0;
      end

      if (accept)
        word_cnt <= word_cnt + WORDS_ONE;

      // a halt seen this cycle freezes the count and beats a simultaneous timeout
      if (state == RUN && !abort && !halt_hit) begin
        cycle_count <= cycle_count + 32'd1;
        if (cycle_count == COUNT_LAST)
          timed_out_q <= 1'b1;
      end

      if (state_next == START && state != START)
        core_program_address <= boot_q;
    end
  end

  assign core_reset = (state == IDLE) || (state == LOAD) || (state == RESET_HOLD);
  assign core_start = (state == START);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller: load, halt, timeout, halt-vs-timeout,
// abort and async reset scenarios with hand-computed expectations.
module tb_core_run_controller;
  localparam int DW   = 32;
  localparam int AB   = 32;
  localparam int MAB  = 3;
  localparam int MAXC = 200;

  logic           clock = 1'b0;
  logic           reset;
  logic           cmd_start, cmd_abort;
  logic [MAB:0]   load_words;
  logic [AB-1:0]  cfg_program_address, cfg_halt_pc0, cfg_halt_pc1;
  logic           core_reset, core_start;
  logic [AB-1:0]  core_program_address;
  logic [AB-1:0]  pc;
  logic           busy, done, timed_out;
  logic [31:0]    cycle_count;

  int total = 0;
  int bad   = 0;

  int          wcount [8];
  logic [31:0] wmem   [8];
  logic [3:0]  last_be;
  logic [31:0] words  [8];

  always #5 clock = ~clock;

  core_run_controller_if #(.DATA_WIDTH(DW), .MEM_ADDRESS_BITS(MAB)) bus ();

  core_run_controller #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .MEM_ADDRESS_BITS(MAB),
    .RESET_CYCLES(4), .DRAIN_CYCLES(50), .MAX_CYCLES(MAXC)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .load_words(load_words), .bus(bus),
    .cfg_program_address(cfg_program_address), .cfg_halt_pc0(cfg_halt_pc0),
    .cfg_halt_pc1(cfg_halt_pc1), .core_reset(core_reset), .core_start(core_start),
    .core_program_address(core_program_address), .pc(pc), .busy(busy), .done(done),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always @(posedge clock) begin
    if (bus.mem_we) begin
      wcount[bus.mem_addr] = wcount[bus.mem_addr] + 1;
      wmem[bus.mem_addr]   = bus.mem_wdata;
      last_be              = bus.mem_byte_en;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_writes();
    for (int i = 0; i < 8; i++) wcount[i] = 0;
    last_be = '0;
  endtask

  task automatic start_run(input logic [31:0] boot, input logic [31:0] h0,
                           input logic [31:0] h1, input int n);
    cfg_program_address = boot;
    cfg_halt_pc0        = h0;
    cfg_halt_pc1        = h1;
    load_words          = (MAB+1)'(n);
    cmd_start           = 1'b1;
    step();
    cmd_start           = 1'b0;
  endtask

  task automatic wait_core_start(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (core_start) break;
      step();
    end
    check(tag, core_start, 1);
  endtask

  task automatic load_burst(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      #1;
      check({tag, "_we"}, bus.mem_we, 1);
      check({tag, "_addr"}, bus.mem_addr, i);
      step();
    end
    bus.load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; load_words = '0;
    cfg_program_address = '0; cfg_halt_pc0 = '0; cfg_halt_pc1 = '0; pc = '0;
    bus.load_valid = 1'b0; bus.load_data = '0;
    for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    words[0] = 32'hDEAD_BEEF; words[1] = 32'hCAFE_F00D; words[2] = 32'h1234_5678;
    clear_writes();
    #12;
    check("rst_core_reset", core_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_core_start", core_start, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_prog_addr", core_program_address, 0);
    @(negedge clock); reset = 1'b0;
    step();

    // 1: three gapped words, then reset hold and start
    start_run(32'h100, 32'hA8, 32'hAC, 3);
    check("t1_load_ready", bus.load_ready, 1);
    check("t1_core_reset", core_reset, 1);
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      #1;
      check("t1_we", bus.mem_we, 1);
      check("t1_addr", bus.mem_addr, i);
      step();
      bus.load_valid = 1'b0;
      if (i < 2) begin
        #1;
        check("t1_gap_we", bus.mem_we, 0);
        step();
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("t1_wcount", wcount[i], 1);
      check("t1_wdata", wmem[i], words[i]);
    end
    check("t1_wcount3", wcount[3], 0);
    check("t1_byte_en", last_be, 4'hF);
    check("t1_ready_off", bus.load_ready, 0);
    for (int k = 0; k < 4; k++) begin
      check("t1_hold_reset", core_reset, 1);
      check("t1_hold_nostart", core_start, 0);
      step();
    end
    check("t1_start", core_start, 1);
    check("t1_start_reset", core_reset, 0);
    check("t1_boot", core_program_address, 32'h100);
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
    check("t1_abort_idle", busy, 0);

    // 2: no load, halt0 after 120 run cycles, 50 drain cycles
    start_run(32'h0, 32'hA8, 32'hAC, 0);
    check("t2_no_ready", bus.load_ready, 0);
    wait_core_start("t2_wait_start");
    check("t2_boot", core_program_address, 0);
    step();
    repeat (120) step();
    check("t2_count_pre", cycle_count, 120);
    pc = 32'hA8;
    step();
    pc = '0;
    check("t2_count_frozen", cycle_count, 120);
    check("t2_drain_busy", busy, 1);
    check("t2_drain_reset", core_reset, 0);
    repeat (49) step();
    check("t2_not_done_49", done, 0);
    step();
    check("t2_done", done, 1);
    check("t2_timed_out", timed_out, 0);
    check("t2_count", cycle_count, 120);
    check("t2_done_reset", core_reset, 0);

    // 3: timeout with no halt, no drain
    start_run(32'h40, 32'hFFFF_0000, 32'hFFFF_0004, 0);
    check("t3_restart_busy", busy, 1);
    check("t3_done_clear", done, 0);
    wait_core_start("t3_wait_start");
    check("t3_boot", core_program_address, 32'h40);
    step();
    repeat (MAXC - 1) step();
    check("t3_count_pre", cycle_count, MAXC - 1);
    check("t3_not_done", done, 0);
    step();
    check("t3_done", done, 1);
    check("t3_timed_out", timed_out, 1);
    check("t3_count", cycle_count, MAXC);
    step();
    check("t3_count_hold", cycle_count, MAXC);

    // 4: halt1 on the limit cycle wins over timeout
    start_run(32'h0, 32'hFFFF_0000, 32'hAC, 0);
    check("t4_to_clear", timed_out, 0);
    wait_core_start("t4_wait_start");
    step();
    repeat (MAXC - 1) step();
    pc = 32'hAC;
    step();
    pc = '0;
    check("t4_drain", done, 0);
    check("t4_drain_busy", busy, 1);
    check("t4_count", cycle_count, MAXC - 1);
    repeat (49) step();
    check("t4_not_done_49", done, 0);
    step();
    check("t4_done", done, 1);
    check("t4_timed_out", timed_out, 0);
    check("t4_count_final", cycle_count, MAXC - 1);

    // 5: abort after 2 of 5 words, reload from address 0, then full-memory load
    clear_writes();
    start_run(32'h200, 32'hA8, 32'hAC, 5);
    load_burst("t5a", 2);
    bus.load_valid = 1'b1; bus.load_data = words[2]; cmd_abort = 1'b1;
    #1;
    check("t5_abort_we", bus.mem_we, 0);
    step();
    bus.load_valid = 1'b0; cmd_abort = 1'b0;
    check("t5_idle", busy, 0);
    check("t5_core_reset", core_reset, 1);
    check("t5_ready", bus.load_ready, 0);
    check("t5_no_write2", wcount[2], 0);
    clear_writes();
    start_run(32'h200, 32'hA8, 32'hAC, 5);
    load_burst("t5b", 5);
    for (int i = 0; i < 5; i++) check("t5_wcount", wcount[i], 1);
    check("t5_hold", core_reset, 1);
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
    clear_writes();
    start_run(32'h0, 32'hA8, 32'hAC, 8);
    load_burst("t5_full", 8);
    for (int i = 0; i < 8; i++) check("t5_full_wcount", wcount[i], 1);
    check("t5_full_ready", bus.load_ready, 0);
    check("t5_full_busy", busy, 1);
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0;

    // 6: cmd_start ignored in RUN, then async reset mid-run
    start_run(32'h300, 32'hA8, 32'hAC, 0);
    wait_core_start("t6_wait_start");
    step();
    repeat (10) step();
    check("t6_count", cycle_count, 10);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_no_restart", core_start, 0);
    check("t6_count_on", cycle_count, 11);
    check("t6_run_reset", core_reset, 0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_core_reset", core_reset, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", cycle_count, 0);
    check("t6_rst_prog", core_program_address, 0);
    check("t6_rst_done", done, 0);
    @(negedge clock); reset = 1'b0;
    step();
    check("t6_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
